issue_queue: RTL and testbench

- Reservation/issue queue directly downstream of the rename stage.
- Captures each renamed instruction (PRN sources with ready bits, PRN destinations, pass-through fields) into a compacting, age-ordered buffer.
- Wakes sources on PRN-ready broadcasts and issues the oldest fully-ready instruction whose functional unit is free, one per cycle.
- Drives a full signal back so the front end stalls.

---
 rtl/issue_queue.sv | 198 +++++++++++++++++++
 tb/tb_issue_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - compacting age-ordered issue queue with PRN wakeup and oldest-ready select
// Optional statistics counters are built when ISSUE_QUEUE_STATS_EN is defined.
module issue_queue #(
    parameter int DEPTH        = 8,
    parameter int MAX_OPERANDS = 3,
    parameter int PRN_BITS     = 6,
    parameter int INST_ID_BITS = 6,
    parameter int FU_COUNT     = 4,
    localparam int FUC_BITS    = $clog2(FU_COUNT)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    input  logic [INST_ID_BITS-1:0]                 in_inst_id,
    input  logic [31:0]                             in_raw_instr,
    input  logic [63:0]                             in_instr_pc,
    input  logic [FUC_BITS-1:0]                     in_fu_choice,
    input  logic [MAX_OPERANDS-1:0]                 in_prn_input_valid,
    input  logic [MAX_OPERANDS-1:0]                 in_prn_input_ready,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_prn_input,
    input  logic [MAX_OPERANDS-1:0]                 in_prn_output_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_prn_output,
    input  logic [MAX_OPERANDS-1:0]                 set_prn_ready_valid,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   set_prn_ready,
    input  logic [FU_COUNT-1:0]                     fu_ready,
    input  logic                                    flush,
    output logic                                    full,
    output logic                                    issue_valid,
    output logic [INST_ID_BITS-1:0]                 issue_inst_id,
    output logic [31:0]                             issue_raw_instr,
    output logic [63:0]                             issue_instr_pc,
    output logic [FUC_BITS-1:0]                     issue_fu_choice,
    output logic [MAX_OPERANDS-1:0]                 issue_prn_input_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   issue_prn_input,
    output logic [MAX_OPERANDS-1:0]                 issue_prn_output_valid,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   issue_prn_output
`ifdef ISSUE_QUEUE_STATS_EN
    ,
    output logic [31:0]                             stat_issued,
    output logic [31:0]                             stat_full_cycles,
    output logic [31:0]                             stat_dropped
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [INST_ID_BITS-1:0]               inst_id;
        logic [31:0]                           raw_instr;
        logic [63:0]                           instr_pc;
        logic [FUC_BITS-1:0]                   fu_choice;
        logic [MAX_OPERANDS-1:0]               src_valid;
        logic [MAX_OPERANDS-1:0]               src_ready;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src;
        logic [MAX_OPERANDS-1:0]               dst_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst;
    } entry_t;

    entry_t                ent       [DEPTH];
    entry_t                ent_woken [DEPTH];
    entry_t                ent_n     [DEPTH];
    entry_t                new_ent;
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      valid_n;
    logic [DEPTH-1:0]      issuable;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      ins_idx;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;
    logic                  accept;

    // Sources whose PRN matches any asserted broadcast port this cycle
    function automatic logic [MAX_OPERANDS-1:0] wake(
        input logic [MAX_OPERANDS-1:0]               sv,
        input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn,
        input logic [MAX_OPERANDS-1:0]               bv,
        input logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] bprn
    );
        logic [MAX_OPERANDS-1:0] w;
        w = '0;
        for (int k = 0; k < MAX_OPERANDS; k++)
            for (int j = 0; j < MAX_OPERANDS; j++)
                if (sv[k] && bv[j] && (bprn[j] == prn[k]))
                    w[k] = 1'b1;
        return w;
    endfunction

    assign full = (count == CNT_W'(DEPTH));

    // Wakeup of stored entries and oldest-first selection over the registered state
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_woken[i] = ent[i];
            ent_woken[i].src_ready = ent[i].src_ready |
                wake(ent[i].src_valid, ent[i].src, set_prn_ready_valid, set_prn_ready);
            issuable[i] = ent_valid[i] && (&(ent[i].src_ready | ~ent[i].src_valid))
                          && fu_ready[ent[i].fu_choice];
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (issuable[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Next entry array: compact over the issued slot, then append the new instruction
    always_comb begin
        new_ent.inst_id   = in_inst_id;
        new_ent.raw_instr = in_raw_instr;
        new_ent.instr_pc  = in_instr_pc;
        new_ent.fu_choice = in_fu_choice;
        new_ent.src_valid = in_prn_input_valid;
        new_ent.src_ready = in_prn_input_ready |
            wake(in_prn_input_valid, in_prn_input, set_prn_ready_valid, set_prn_ready);
        new_ent.src       = in_prn_input;
        new_ent.dst_valid = in_prn_output_valid;
        new_ent.dst       = in_prn_output;
        // A full queue still takes an instruction when an issue frees a slot this cycle
        accept  = in_valid && (!full || sel_found);
        ins_idx = sel_found ? (count - CNT_W'(1)) : count;
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i]   = ent_woken[i];
            valid_n[i] = ent_valid[i];
        end
        if (sel_found) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    ent_n[i]   = ent_woken[i+1];
                    valid_n[i] = ent_valid[i+1];
                end
            end
            ent_n[DEPTH-1]   = '0;
            valid_n[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (CNT_W'(i) == ins_idx)) begin
                ent_n[i]   = new_ent;
                valid_n[i] = 1'b1;
            end
        end
    end

    // Queue state and registered issue port; flush discards everything like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            ent_valid              <= '0;
            count                  <= '0;
            issue_valid            <= 1'b0;
            issue_inst_id          <= '0;
            issue_raw_instr        <= '0;
            issue_instr_pc         <= '0;
            issue_fu_choice        <= '0;
            issue_prn_input_valid  <= '0;
            issue_prn_input        <= '0;
            issue_prn_output_valid <= '0;
            issue_prn_output       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= ent_n[i];
            ent_valid   <= valid_n;
            count       <= count + CNT_W'(accept) - CNT_W'(sel_found);
            issue_valid <= sel_found;
            if (sel_found) begin
                issue_inst_id          <= ent[sel_idx].inst_id;
                issue_raw_instr        <= ent[sel_idx].raw_instr;
                issue_instr_pc         <= ent[sel_idx].instr_pc;
                issue_fu_choice        <= ent[sel_idx].fu_choice;
                issue_prn_input_valid  <= ent[sel_idx].src_valid;
                issue_prn_input        <= ent[sel_idx].src;
                issue_prn_output_valid <= ent[sel_idx].dst_valid;
                issue_prn_output       <= ent[sel_idx].dst;
            end
        end
    end

`ifdef ISSUE_QUEUE_STATS_EN
    // Saturating statistics; survive flush, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued      <= '0;
            stat_full_cycles <= '0;
            stat_dropped     <= '0;
        end else begin
            if (sel_found && !flush && (stat_issued != '1))
                stat_issued <= stat_issued + 32'd1;
            if (full && (stat_full_cycles != '1))
                stat_full_cycles <= stat_full_cycles + 32'd1;
            if (in_valid && full && !sel_found && (stat_dropped != '1))
                stat_dropped <= stat_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue
module tb_issue_queue;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [5:0]       in_inst_id;
    logic [31:0]      in_raw_instr;
    logic [63:0]      in_instr_pc;
    logic [1:0]       in_fu_choice;
    logic [2:0]       in_prn_input_valid;
    logic [2:0]       in_prn_input_ready;
    logic [2:0][5:0]  in_prn_input;
    logic [2:0]       in_prn_output_valid;
    logic [2:0][5:0]  in_prn_output;
    logic [2:0]       set_prn_ready_valid;
    logic [2:0][5:0]  set_prn_ready;
    logic [3:0]       fu_ready;
    logic             flush;
    logic             full;
    logic             issue_valid;
    logic [5:0]       issue_inst_id;
    logic [31:0]      issue_raw_instr;
    logic [63:0]      issue_instr_pc;
    logic [1:0]       issue_fu_choice;
    logic [2:0]       issue_prn_input_valid;
    logic [2:0][5:0]  issue_prn_input;
    logic [2:0]       issue_prn_output_valid;
    logic [2:0][5:0]  issue_prn_output;
`ifdef ISSUE_QUEUE_STATS_EN
    logic [31:0]      stat_issued;
    logic [31:0]      stat_full_cycles;
    logic [31:0]      stat_dropped;
`endif

    int vectors    = 0;
    int miscompares = 0;

    issue_queue dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_inst_id             (in_inst_id),
        .in_raw_instr           (in_raw_instr),
        .in_instr_pc            (in_instr_pc),
        .in_fu_choice           (in_fu_choice),
        .in_prn_input_valid     (in_prn_input_valid),
        .in_prn_input_ready     (in_prn_input_ready),
        .in_prn_input           (in_prn_input),
        .in_prn_output_valid    (in_prn_output_valid),
        .in_prn_output          (in_prn_output),
        .set_prn_ready_valid    (set_prn_ready_valid),
        .set_prn_ready          (set_prn_ready),
        .fu_ready               (fu_ready),
        .flush                  (flush),
        .full                   (full),
        .issue_valid            (issue_valid),
        .issue_inst_id          (issue_inst_id),
        .issue_raw_instr        (issue_raw_instr),
        .issue_instr_pc         (issue_instr_pc),
        .issue_fu_choice        (issue_fu_choice),
        .issue_prn_input_valid  (issue_prn_input_valid),
        .issue_prn_input        (issue_prn_input),
        .issue_prn_output_valid (issue_prn_output_valid),
        .issue_prn_output       (issue_prn_output)
`ifdef ISSUE_QUEUE_STATS_EN
        ,
        .stat_issued            (stat_issued),
        .stat_full_cycles       (stat_full_cycles),
        .stat_dropped           (stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one instruction with source slot 0 used (PRN p0, ready flag r0)
    task automatic put(input logic [5:0] id, input logic [1:0] fu, input logic r0, input logic [5:0] p0);
        in_valid               = 1'b1;
        in_inst_id             = id;
        in_raw_instr           = 32'hA000_0000 | 32'(id);
        in_instr_pc            = 64'h1000 + 64'(id);
        in_fu_choice           = fu;
        in_prn_input_valid     = 3'b001;
        in_prn_input_ready     = {2'b00, r0};
        in_prn_input           = '0;
        in_prn_input[0]        = p0;
        in_prn_output_valid    = 3'b001;
        in_prn_output          = '0;
        in_prn_output[0]       = id + 6'd20;
    endtask

    task automatic bcast(input logic [2:0] v, input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        set_prn_ready_valid = v;
        set_prn_ready[0]    = a;
        set_prn_ready[1]    = b;
        set_prn_ready[2]    = c;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_inst_id = '0; in_raw_instr = '0; in_instr_pc = '0; in_fu_choice = '0;
        in_prn_input_valid = '0; in_prn_input_ready = '0; in_prn_input = '0;
        in_prn_output_valid = '0; in_prn_output = '0;
        set_prn_ready_valid = '0; set_prn_ready = '0; fu_ready = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_issue_id", 64'(issue_inst_id), 64'd0);
        chk("rst_count", 64'(dut.count), 64'd0);

        // Ready instruction to FU 2 issues one cycle after acceptance
        fu_ready = 4'b0100;
        put(6'd5, 2'd2, 1'b1, 6'd3);
        tick();
        in_valid = 1'b0;
        chk("t1_not_yet", 64'(issue_valid), 64'd0);
        tick();
        chk("t1_issue_valid", 64'(issue_valid), 64'd1);
        chk("t1_issue_id", 64'(issue_inst_id), 64'd5);
        chk("t1_issue_fu", 64'(issue_fu_choice), 64'd2);
        chk("t1_issue_raw", 64'(issue_raw_instr), 64'hA000_0005);
        chk("t1_issue_pc", issue_instr_pc, 64'h1005);
        chk("t1_full", 64'(full), 64'd0);
        tick();
        chk("t1_strobe_drop", 64'(issue_valid), 64'd0);
        chk("t1_hold_id", 64'(issue_inst_id), 64'd5);

        // Younger ready instruction bypasses older waiting one; wakeup releases it
        fu_ready = 4'hF;
        put(6'd1, 2'd0, 1'b0, 6'd12);
        tick();
        put(6'd2, 2'd1, 1'b1, 6'd13);
        tick();
        in_valid = 1'b0;
        chk("t2_none_ready", 64'(issue_valid), 64'd0);
        tick();
        chk("t2_young_valid", 64'(issue_valid), 64'd1);
        chk("t2_young_id", 64'(issue_inst_id), 64'd2);
        bcast(3'b010, 6'd0, 6'd12, 6'd0);
        tick();
        bcast(3'b000, 6'd0, 6'd0, 6'd0);
        chk("t2_wake_edge", 64'(issue_valid), 64'd0);
        tick();
        chk("t2_old_valid", 64'(issue_valid), 64'd1);
        chk("t2_old_id", 64'(issue_inst_id), 64'd1);
        tick();
        chk("t2_empty", 64'(dut.count), 64'd0);

        // Fill with eight waiting instructions (ids 16..23, PRNs 40..47)
        for (int k = 0; k < 8; k++) begin
            put(6'(16 + k), 2'd0, 1'b0, 6'(40 + k));
            tick();
        end
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_count8", 64'(dut.count), 64'd8);
        put(6'd24, 2'd0, 1'b1, 6'd1);
        tick();
        in_valid = 1'b0;
        chk("t3_drop_count", 64'(dut.count), 64'd8);
        chk("t3_drop_full", 64'(full), 64'd1);
        chk("t3_drop_top", 64'(dut.ent[7].inst_id), 64'd23);

        // Full queue: issue index 0 and insert in the same cycle
        bcast(3'b001, 6'd40, 6'd0, 6'd0);
        tick();
        bcast(3'b000, 6'd0, 6'd0, 6'd0);
        chk("t5_wake_edge", 64'(issue_valid), 64'd0);
        put(6'd25, 2'd0, 1'b0, 6'd50);
        tick();
        in_valid = 1'b0;
        chk("t5_issue_id", 64'(issue_inst_id), 64'd16);
        chk("t5_count", 64'(dut.count), 64'd8);
        chk("t5_new_at7", 64'(dut.ent[7].inst_id), 64'd25);
        chk("t5_head", 64'(dut.ent[0].inst_id), 64'd17);
        bcast(3'b111, 6'd41, 6'd47, 6'd50);
        tick();
        bcast(3'b000, 6'd0, 6'd0, 6'd0);
        chk("t5_wake2_edge", 64'(issue_valid), 64'd0);
        tick();
        chk("t5_age1", 64'(issue_inst_id), 64'd17);
        tick();
        chk("t5_age2", 64'(issue_inst_id), 64'd23);
        tick();
        chk("t5_age3", 64'(issue_inst_id), 64'd25);
        chk("t5_age3_valid", 64'(issue_valid), 64'd1);
        tick();
        chk("t5_idle", 64'(issue_valid), 64'd0);
        chk("t5_count5", 64'(dut.count), 64'd5);

        // Flush with five entries and a concurrent ready insert
        flush = 1'b1;
        put(6'd30, 2'd0, 1'b1, 6'd2);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t6_count", 64'(dut.count), 64'd0);
        chk("t6_issue_valid", 64'(issue_valid), 64'd0);
        chk("t6_issue_id", 64'(issue_inst_id), 64'd0);
        chk("t6_full", 64'(full), 64'd0);
        bcast(3'b111, 6'd42, 6'd43, 6'd44);
        tick();
        chk("t6_quiet1", 64'(issue_valid), 64'd0);
        bcast(3'b011, 6'd45, 6'd46, 6'd0);
        tick();
        bcast(3'b000, 6'd0, 6'd0, 6'd0);
        chk("t6_quiet2", 64'(issue_valid), 64'd0);
        tick();
        chk("t6_quiet3", 64'(issue_valid), 64'd0);
        tick();
        chk("t6_quiet4", 64'(issue_valid), 64'd0);

        // Same-cycle wakeup of the instruction being inserted
        put(6'd9, 2'd3, 1'b0, 6'd7);
        bcast(3'b100, 6'd0, 6'd0, 6'd7);
        tick();
        in_valid = 1'b0;
        bcast(3'b000, 6'd0, 6'd0, 6'd0);
        chk("t4_accept_edge", 64'(issue_valid), 64'd0);
        tick();
        chk("t4_issue_valid", 64'(issue_valid), 64'd1);
        chk("t4_issue_id", 64'(issue_inst_id), 64'd9);
        chk("t4_src_valid", 64'(issue_prn_input_valid), 64'd1);
        chk("t4_src_prn", 64'(issue_prn_input[0]), 64'd7);
        chk("t4_dst_valid", 64'(issue_prn_output_valid), 64'd1);
        chk("t4_dst_prn", 64'(issue_prn_output[0]), 64'd29);
        tick();
        chk("t4_empty", 64'(dut.count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
